// File: rtl/aes_ctrl_fsm.sv
// aes_ctrl_fsm -- AES block-job sequencer.
//
// Walks a job of nblocks 128-bit blocks: kicks off key expansion once, then
// for every block starts the source/sink streamers and the cipher engine
// together, waits for the engine, advances the block addresses and finally
// waits for the streamers to drain before signalling completion.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   clear_i                   synchronous soft clear (acts like reset)
//   start_i                   job start pulse, sampled in IDLE only
//   src_addr_i, dst_addr_i    job base byte addresses (latched at start)
//   nblocks_i                 job length in blocks (latched at start)
//   key_load_o / key_done_i   key-expansion start pulse / completion
//   src_ready_start_i,
//   sink_ready_start_i        streamers can accept a new transfer
//   src_req_start_o,
//   sink_req_start_o          streamer transfer start pulses
//   src_base_addr_o,
//   sink_base_addr_o          current block addresses
//   trans_size_o              transfer size in 32-bit words (constant)
//   engine_start_o,
//   engine_clear_o,
//   engine_done_i             cipher engine control / completion
//   done_o, evt_o             job-complete pulses
//   busy_o                    job active
//   blk_cnt_o                 blocks completed in the current job
//
// State table
//   IDLE      | waiting for start_i; engine held in clear
//   KEYEXP    | key expansion running, waiting for key_done_i
//   START     | waiting for both streamers, then fires the start triple
//   COMPUTE   | engine encrypting the current block
//   UPDATE    | one cycle: bump block count and address offset
//   TERMINATE | waiting for the streamers to drain, then done pulse

module aes_ctrl_fsm #(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int BLK_BYTES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [CNT_W-1:0]  nblocks_i,
    output logic              key_load_o,
    input  logic              key_done_i,
    input  logic              src_ready_start_i,
    input  logic              sink_ready_start_i,
    output logic              src_req_start_o,
    output logic              sink_req_start_o,
    output logic [ADDR_W-1:0] src_base_addr_o,
    output logic [ADDR_W-1:0] sink_base_addr_o,
    output logic [CNT_W-1:0]  trans_size_o,
    output logic              engine_start_o,
    output logic              engine_clear_o,
    input  logic              engine_done_i,
    output logic              done_o,
    output logic              evt_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  blk_cnt_o
);

    localparam logic [ADDR_W-1:0] BLK_STEP    = ADDR_W'(BLK_BYTES);
    localparam logic [CNT_W-1:0]  TRANS_WORDS = CNT_W'(BLK_BYTES / 4);

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        START,
        COMPUTE,
        UPDATE,
        TERMINATE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [CNT_W-1:0]  nblk_q, nblk_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    // An empty job completes without running; its done pulse comes from this
    // flop one cycle after the start.
    logic              zero_done_q, zero_done_d;
    logic              term_done;
    logic              streams_ready;
    logic [CNT_W-1:0]  blk_cnt_inc;

    assign streams_ready = src_ready_start_i & sink_ready_start_i;
    assign blk_cnt_inc   = blk_cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            offset_q    <= '0;
            nblk_q      <= '0;
            blk_cnt_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            offset_q    <= offset_d;
            nblk_q      <= nblk_d;
            blk_cnt_q   <= blk_cnt_d;
            zero_done_q <= zero_done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        src_d            = src_q;
        dst_d            = dst_q;
        offset_d         = offset_q;
        nblk_d           = nblk_q;
        blk_cnt_d        = blk_cnt_q;
        zero_done_d      = 1'b0;
        key_load_o       = 1'b0;
        src_req_start_o  = 1'b0;
        sink_req_start_o = 1'b0;
        engine_start_o   = 1'b0;
        engine_clear_o   = 1'b0;
        term_done        = 1'b0;

        case (state_q)
            IDLE: begin
                engine_clear_o = 1'b1;
                if (start_i && !clear_i) begin
                    if (nblocks_i != '0) begin
                        src_d      = src_addr_i;
                        dst_d      = dst_addr_i;
                        nblk_d     = nblocks_i;
                        blk_cnt_d  = '0;
                        offset_d   = '0;
                        key_load_o = 1'b1;
                        state_d    = KEYEXP;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            KEYEXP: begin
                if (key_done_i) begin
                    state_d = START;
                end
            end
            START: begin
                if (streams_ready) begin
                    src_req_start_o  = 1'b1;
                    sink_req_start_o = 1'b1;
                    engine_start_o   = 1'b1;
                    state_d          = COMPUTE;
                end
            end
            COMPUTE: begin
                if (engine_done_i) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                blk_cnt_d = blk_cnt_inc;
                offset_d  = offset_q + BLK_STEP;
                state_d   = (blk_cnt_inc == nblk_q) ? TERMINATE : START;
            end
            TERMINATE: begin
                // The sink accepting a new transfer means the last block has
                // been written out.
                if (streams_ready && !clear_i) begin
                    term_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d     = IDLE;
            src_d       = '0;
            dst_d       = '0;
            offset_d    = '0;
            nblk_d      = '0;
            blk_cnt_d   = '0;
            zero_done_d = 1'b0;
        end
    end

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign src_base_addr_o  = src_q + offset_q;
    assign sink_base_addr_o = dst_q + offset_q;
    assign trans_size_o     = TRANS_WORDS;
    assign done_o           = zero_done_q | term_done;
    assign evt_o            = zero_done_q | term_done;
    assign busy_o           = (state_q != IDLE);
    assign blk_cnt_o        = blk_cnt_q;

endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// tb_aes_ctrl_fsm -- scoreboard bench for aes_ctrl_fsm.
//
// Stimulus pushes the expected streamer request addresses and the expected
// blk_cnt at job completion into queues; a negedge monitor pops and compares
// whenever the DUT raises src_req_start_o or done_o. Small responder
// processes model the key-expansion unit and the cipher engine latencies.

module tb_aes_ctrl_fsm;

    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 16;
    localparam int BLK_BYTES = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [CNT_W-1:0]  nblocks = '0;
    logic              key_load;
    logic              key_done;
    logic              src_ready = 1'b1;
    logic              sink_ready = 1'b1;
    logic              src_req;
    logic              sink_req;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] sink_base;
    logic [CNT_W-1:0]  trans_size;
    logic              engine_start;
    logic              engine_clear;
    logic              engine_done = 1'b0;
    logic              done;
    logic              evt;
    logic              busy;
    logic [CNT_W-1:0]  blk_cnt;

    logic key_pulse  = 1'b0;
    logic key_always = 1'b0;
    assign key_done = key_pulse | key_always;

    int key_lat = 2;
    int eng_lat = 2;

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
    } req_t;

    req_t exp_req[$];
    int   exp_done[$];
    req_t mon_req;
    int   mon_cnt;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_req  = 0;
    int n_done = 0;
    int n_kl   = 0;

    always #5 clk = ~clk;

    aes_ctrl_fsm #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .BLK_BYTES(BLK_BYTES)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .clear_i           (clear),
        .start_i           (start),
        .src_addr_i        (src_addr),
        .dst_addr_i        (dst_addr),
        .nblocks_i         (nblocks),
        .key_load_o        (key_load),
        .key_done_i        (key_done),
        .src_ready_start_i (src_ready),
        .sink_ready_start_i(sink_ready),
        .src_req_start_o   (src_req),
        .sink_req_start_o  (sink_req),
        .src_base_addr_o   (src_base),
        .sink_base_addr_o  (sink_base),
        .trans_size_o      (trans_size),
        .engine_start_o    (engine_start),
        .engine_clear_o    (engine_clear),
        .engine_done_i     (engine_done),
        .done_o            (done),
        .evt_o             (evt),
        .busy_o            (busy),
        .blk_cnt_o         (blk_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_load) n_kl++;
            if (src_req) begin
                n_req++;
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_req: src 0x%0h dst 0x%0h, none expected",
                             src_base, sink_base);
                end else begin
                    mon_req = exp_req.pop_front();
                    chk("req_src_addr", src_base, mon_req.src);
                    chk("req_dst_addr", sink_base, mon_req.dst);
                    chk("req_triple", {sink_req, engine_start}, 2'b11);
                end
            end
            if (done) begin
                n_done++;
                if (exp_done.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: blk_cnt %0d, none expected", blk_cnt);
                end else begin
                    mon_cnt = exp_done.pop_front();
                    chk("done_blk_cnt", blk_cnt, mon_cnt);
                    chk("evt_with_done", evt, 1);
                end
            end
        end
    end

    // Key-expansion unit model.
    initial forever begin
        @(negedge clk);
        if (key_load) begin
            repeat (key_lat) @(posedge clk);
            #1 key_pulse = 1'b1;
            @(posedge clk);
            #1 key_pulse = 1'b0;
        end
    end

    // Cipher engine model.
    initial forever begin
        @(negedge clk);
        if (engine_start) begin
            repeat (eng_lat) @(posedge clk);
            #1 engine_done = 1'b1;
            @(posedge clk);
            #1 engine_done = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input logic [CNT_W-1:0] n);
        src_addr = s;
        dst_addr = d;
        nblocks  = n;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic push_req(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d);
        req_t r;
        r.src = s;
        r.dst = d;
        exp_req.push_back(r);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0;
        int k;
        n0 = n_done;
        k  = 0;
        while (n_done == n0 && k < budget) begin
            tick(1);
            k++;
        end
        chk({name, "_done_seen"}, (n_done > n0) ? 1 : 0, 1);
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, k0, d0, k;

        // Reset state
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_engine_clear", engine_clear, 1);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_key_load", key_load, 0);
        chk("rst_done", done, 0);
        chk("rst_src_req", src_req, 0);
        chk("rst_src_base", src_base, 0);
        chk("trans_size", trans_size, BLK_BYTES / 4);
        rst_n = 1'b1;
        tick(2);

        // Single block
        key_lat = 10;
        eng_lat = 12;
        r0 = n_req; k0 = n_kl;
        push_req(32'h1C01_0000, 32'h1C01_0400);
        exp_done.push_back(1);
        start_job(32'h1C01_0000, 32'h1C01_0400, 16'd1);
        chk("single_busy", busy, 1);
        wait_done("single", 200);
        chk("single_blk_cnt", blk_cnt, 1);
        chk("single_busy_fell", busy, 0);
        chk("single_req_count", n_req - r0, 1);
        chk("single_keyload_count", n_kl - k0, 1);

        // Four blocks; config inputs change and start_i pulses mid-job
        key_lat = 2;
        eng_lat = 3;
        r0 = n_req; k0 = n_kl;
        for (int i = 0; i < 4; i++)
            push_req(32'h4000_0000 + 32'(i * 16), 32'h5000_0000 + 32'(i * 16));
        exp_done.push_back(4);
        start_job(32'h4000_0000, 32'h5000_0000, 16'd4);
        src_addr = 32'hDEAD_BEEF;
        dst_addr = 32'hCAFE_0000;
        nblocks  = 16'd1;
        tick(8);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("four", 300);
        chk("four_blk_cnt", blk_cnt, 4);
        chk("four_req_count", n_req - r0, 4);
        chk("four_keyload_count", n_kl - k0, 1);

        // Clear from IDLE zeroes blk_cnt; clear beats start
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clear_blk_cnt", blk_cnt, 0);
        k0 = n_kl;
        nblocks = 16'd3;
        clear = 1'b1;
        start = 1'b1;
        #1;
        chk("clear_prio_key_load", key_load, 0);
        tick(1);
        clear = 1'b0;
        start = 1'b0;
        chk("clear_prio_busy", busy, 0);
        chk("clear_prio_keyload_count", n_kl - k0, 0);

        // Empty job
        r0 = n_req; k0 = n_kl;
        exp_done.push_back(0);
        src_addr = 32'h0000_1234;
        nblocks  = 16'd0;
        start    = 1'b1;
        #1;
        chk("zero_done_same_cycle", done, 0);
        chk("zero_key_load", key_load, 0);
        tick(1);
        start = 1'b0;
        chk("zero_done_next_cycle", done, 1);
        chk("zero_busy", busy, 0);
        tick(1);
        chk("zero_done_one_cycle", done, 0);
        chk("zero_req_count", n_req - r0, 0);
        chk("zero_keyload_count", n_kl - k0, 0);

        // Sink backpressure in START
        key_lat = 1;
        eng_lat = 2;
        r0 = n_req;
        sink_ready = 1'b0;
        push_req(32'h0000_2000, 32'h0000_3000);
        exp_done.push_back(1);
        start_job(32'h0000_2000, 32'h0000_3000, 16'd1);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_no_req", src_req, 0);
            tick(1);
        end
        sink_ready = 1'b1;
        #1;
        chk("bp_first_ready_req", src_req, 1);
        wait_done("bp", 100);
        chk("bp_req_count", n_req - r0, 1);

        // Address wrap-around
        push_req(32'hFFFF_FFF0, 32'h0000_0100);
        push_req(32'h0000_0000, 32'h0000_0110);
        exp_done.push_back(2);
        start_job(32'hFFFF_FFF0, 32'h0000_0100, 16'd2);
        wait_done("wrap", 200);
        chk("wrap_blk_cnt", blk_cnt, 2);

        // Clear during COMPUTE of block 2 of 3, then a fresh job
        key_lat = 2;
        eng_lat = 20;
        r0 = n_req;
        push_req(32'h0000_8000, 32'h0000_9000);
        push_req(32'h0000_8010, 32'h0000_9010);
        start_job(32'h0000_8000, 32'h0000_9000, 16'd3);
        k = 0;
        while (n_req < r0 + 2 && k < 300) begin
            tick(1);
            k++;
        end
        chk("clr_reached_blk2", (n_req >= r0 + 2) ? 1 : 0, 1);
        tick(3);
        d0 = n_done;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_blk_cnt", blk_cnt, 0);
        chk("clr_engine_clear", engine_clear, 1);
        chk("clr_src_base", src_base, 0);
        tick(30);
        chk("clr_no_done", n_done - d0, 0);
        chk("clr_still_idle", busy, 0);
        eng_lat = 2;
        push_req(32'h0000_0500, 32'h0000_0600);
        exp_done.push_back(1);
        start_job(32'h0000_0500, 32'h0000_0600, 16'd1);
        wait_done("after_clear", 100);
        chk("after_clear_blk_cnt", blk_cnt, 1);

        // Minimum start-to-request latency with key already expanded
        key_always = 1'b1;
        push_req(32'h0000_0700, 32'h0000_0800);
        exp_done.push_back(1);
        start_job(32'h0000_0700, 32'h0000_0800, 16'd1);
        chk("lat_cycle1_no_req", src_req, 0);
        tick(1);
        chk("lat_cycle2_req", src_req, 1);
        wait_done("lat", 100);
        key_always = 1'b0;

        tick(5);
        chk("leftover_req", exp_req.size(), 0);
        chk("leftover_done", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_ctrl_fsm.md
AES_CTRL_FSM -- requirements
Module: aes_ctrl_fsm

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; CNT_W, default 16, block-count width; BLK_BYTES, default 16, bytes per AES block.
REQ-002 clk_i  in  1  clock, all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 clear_i  in  1  synchronous soft clear.
REQ-005 start_i  in  1  job start pulse from the register slave.
REQ-006 src_addr_i, dst_addr_i  in  ADDR_W  job source and destination base byte addresses.
REQ-007 nblocks_i  in  CNT_W  number of 128-bit blocks in the job.
REQ-008 key_load_o  out  1  one-cycle key-expansion start; key_done_i  in  1  key expansion finished.
REQ-009 src_ready_start_i, sink_ready_start_i  in  1  each streamer can accept a new transfer.
REQ-010 src_req_start_o, sink_req_start_o  out  1  streamer transfer start pulses.
REQ-011 src_base_addr_o, sink_base_addr_o  out  ADDR_W  current block addresses; trans_size_o  out  CNT_W  constant BLK_BYTES/4 words.
REQ-012 engine_start_o, engine_clear_o  out  1  engine controls; engine_done_i  in  1  block encryption complete.
REQ-013 done_o, evt_o  out  1  job-complete pulses; busy_o  out  1  job active; blk_cnt_o  out  CNT_W  blocks completed.

Function
REQ-014 States SHALL be IDLE, KEYEXP, START, COMPUTE, UPDATE, TERMINATE, encoded in a single registered state variable.
REQ-015 IDLE: busy_o=0, engine_clear_o=1; start_i with nblocks_i!=0 latches src/dst/nblocks, zeroes blk_cnt, pulses key_load_o, goes to KEYEXP.
REQ-016 IDLE with start_i and nblocks_i==0: done_o and evt_o pulse for one cycle in the next cycle; no streamer or key activity; stays IDLE.
REQ-017 KEYEXP: holds until key_done_i=1, then goes to START; key_load_o is not reasserted.
REQ-018 START: when src_ready_start_i & sink_ready_start_i, src_req_start_o, sink_req_start_o and engine_start_o are 1 in that same cycle (combinational), then COMPUTE; otherwise all three stay 0 and the FSM stays in START.
REQ-019 COMPUTE: engine_clear_o=0; engine_done_i=1 moves to UPDATE; start_i is ignored.
REQ-020 UPDATE (one cycle): blk_cnt increments; offset increments by BLK_BYTES; if the incremented blk_cnt equals the latched nblocks, go to TERMINATE, else go to START.
REQ-021 src_base_addr_o = latched src + blk_cnt*BLK_BYTES and sink_base_addr_o = latched dst + blk_cnt*BLK_BYTES, both modulo 2^ADDR_W (wrap-around without error).
REQ-022 TERMINATE: waits for src_ready_start_i & sink_ready_start_i (sink drained); in that cycle done_o=1 and evt_o=1, next state IDLE.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 start_i asserted in any state other than IDLE SHALL be ignored and SHALL NOT alter the latched configuration.
REQ-025 Changes to the config inputs after the start pulse SHALL have no effect on the running job.
REQ-026 engine_done_i outside COMPUTE and key_done_i outside KEYEXP SHALL be ignored.
REQ-027 Latency: start_i to the first src_req_start_o is at least 2 cycles (IDLE->KEYEXP->START, when key_done_i is already 1 in KEYEXP); each subsequent block costs COMPUTE time +2 cycles (UPDATE, START) when the streamers are ready.

Reset
REQ-028 On rst_ni=0: state=IDLE, blk_cnt=0, latched registers=0; all pulse outputs=0; busy_o=0; engine_clear_o=1.
REQ-029 clear_i=1 SHALL have the same effect as reset on the next edge from any state, with no done_o/evt_o pulse; clear_i has priority over start_i.

Verification
REQ-030 Single block: src=0x1C010000, dst=0x1C010400, nblocks=1, key_done after 10 cycles, engine_done after 12 -> one req_start triple at 0x1C010000/0x1C010400, blk_cnt_o=1, one done_o pulse, busy_o falls.
REQ-031 Four blocks -> four req_start triples at src offsets 0x00, 0x10, 0x20, 0x30; done_o only after the fourth; blk_cnt_o=4.
REQ-032 nblocks=0 -> done_o one cycle after start_i, no key_load_o, no req_start.
REQ-033 Streamer backpressure: sink_ready_start_i=0 for 5 cycles in START -> no req_start pulses during those cycles; triple issued in the first ready cycle.
REQ-034 Address wrap: src=0xFFFFFFF0, nblocks=2 -> second block src_base_addr_o=0x00000000.
REQ-035 clear_i during COMPUTE of block 2 of 3 -> IDLE next cycle, blk_cnt_o=0, no done_o; a new start_i then runs normally.
